// File: rtl/pipe_pkg.sv
// Shared pipeline types: register index width, stage count and the scoreboard entry.
package pipe_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned INFL_W     = $clog2(NUM_STAGES + 1);
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     is_load;
    logic     reg_write;
  } sb_entry_t;

  // An entry holds a pending-count reference only if it really writes a non-x0 register.
  function automatic logic entry_counts(input sb_entry_t e);
    return e.valid & e.reg_write & (e.rd != '0);
  endfunction

endpackage

// File: rtl/sb_stage_pipe.sv
// EX -> ME -> WB entry shifter for the hazard scoreboard.
module sb_stage_pipe
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              flush,
  input  sb_entry_t         ex_in,
  output sb_entry_t         ex_o,
  output logic              wb_counts_c,
  output reg_idx_t          wb_rd_o,
  output logic [INFL_W-1:0] n_valid_c
);

  sb_entry_t ex_q, ex_d;
  sb_entry_t me_q, me_d;
  sb_entry_t wb_q, wb_d;

  always_comb begin
    ex_d = ex_q;
    me_d = me_q;
    wb_d = wb_q;
    if (advance) begin
      wb_d = me_q;
      me_d = ex_q;
      // A squashed EX instruction still travels down as a dead bubble
      if (flush) me_d.valid = 1'b0;
      ex_d = ex_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
      me_q <= '0;
      wb_q <= '0;
    end else begin
      ex_q <= ex_d;
      me_q <= me_d;
      wb_q <= wb_d;
    end
  end

  assign ex_o        = ex_q;
  assign wb_rd_o     = wb_q.rd;
  assign wb_counts_c = entry_counts(wb_q);
  assign n_valid_c   = INFL_W'(ex_d.valid) + INFL_W'(me_d.valid) + INFL_W'(wb_d.valid);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register pending counts, load-use detection and
// a sticky check that retiring writebacks agree with the tracked WB entry.
module hazard_scoreboard
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  reg_idx_t          issue_rd,
  input  logic              issue_reg_write,
  input  logic              issue_is_load,
  input  reg_idx_t          ID_rs1,
  input  reg_idx_t          ID_rs2,
  input  logic              stall_mem,
  input  logic              flush_ex,
  input  logic              wb_valid,
  input  reg_idx_t          wb_rd,
  output logic              load_use_stall,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic [INFL_W-1:0] inflight_cnt,
  output logic              sb_error
);

  logic              advance;
  logic              accept;
  logic              lu_hit;
  logic              issue_counts;
  logic              ex_flush_counts;
  logic              wb_counts;
  logic              wb_mismatch;
  logic              sat_err;
  reg_idx_t          wb_entry_rd;
  logic [INFL_W-1:0] n_valid;
  sb_entry_t         ex_entry;
  sb_entry_t         ex_in;

  cnt_t              cnt_q [NUM_REGS];
  cnt_t              cnt_d [NUM_REGS];
  logic              sb_error_q, sb_error_d;
  logic [INFL_W-1:0] inflight_cnt_q;

  sb_stage_pipe u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (advance),
    .flush       (flush_ex),
    .ex_in       (ex_in),
    .ex_o        (ex_entry),
    .wb_counts_c (wb_counts),
    .wb_rd_o     (wb_entry_rd),
    .n_valid_c   (n_valid)
  );

  assign advance = ~stall_mem;
  assign lu_hit  = ex_entry.valid & ex_entry.is_load & ex_entry.reg_write &
                   (ex_entry.rd != '0) &
                   ((ex_entry.rd == ID_rs1) | (ex_entry.rd == ID_rs2));
  assign accept  = issue_valid & advance & ~lu_hit & ~flush_ex;

  assign issue_counts    = issue_reg_write & (issue_rd != '0);
  assign ex_flush_counts = flush_ex & entry_counts(ex_entry);

  // Offered instruction enters EX only when accepted; otherwise a bubble
  always_comb begin
    ex_in = '0;
    if (accept) begin
      ex_in.valid     = 1'b1;
      ex_in.rd        = issue_rd;
      ex_in.is_load   = issue_is_load;
      ex_in.reg_write = issue_reg_write;
    end
  end

  // Per-register pending counts with saturation; a same-cycle inc/dec cancels out
  always_comb begin
    int sum;
    sum     = 0;
    sat_err = 1'b0;
    for (int r = 0; r < int'(NUM_REGS); r++) cnt_d[r] = cnt_q[r];
    if (advance) begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        sum = int'(cnt_q[r]);
        if (accept && issue_counts && (issue_rd == reg_idx_t'(r))) sum = sum + 1;
        if (wb_counts && (wb_entry_rd == reg_idx_t'(r)))           sum = sum - 1;
        if (ex_flush_counts && (ex_entry.rd == reg_idx_t'(r)))     sum = sum - 1;
        if (sum > int'(CNT_MAX)) begin
          cnt_d[r] = cnt_t'(CNT_MAX);
          sat_err  = 1'b1;
        end else if (sum < 0) begin
          cnt_d[r] = '0;
          sat_err  = 1'b1;
        end else begin
          cnt_d[r] = cnt_t'(sum);
        end
      end
    end
  end

  assign wb_mismatch = (wb_valid != wb_counts) ||
                       (wb_valid && wb_counts && (wb_rd != wb_entry_rd));
  assign sb_error_d  = sb_error_q | (advance & (wb_mismatch | sat_err));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= '0;
      sb_error_q     <= 1'b0;
      inflight_cnt_q <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) cnt_q[r] <= cnt_d[r];
      sb_error_q     <= sb_error_d;
      inflight_cnt_q <= n_valid;
    end
  end

  assign load_use_stall = rst_n & lu_hit;
  assign rs1_pending    = rst_n & (ID_rs1 != '0) & (cnt_q[ID_rs1] != '0);
  assign rs2_pending    = rst_n & (ID_rs2 != '0) & (cnt_q[ID_rs2] != '0);
  assign inflight_cnt   = inflight_cnt_q;
  assign sb_error       = sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic       issue_reg_write;
  logic       issue_is_load;
  logic [4:0] ID_rs1;
  logic [4:0] ID_rs2;
  logic       stall_mem;
  logic       flush_ex;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       load_use_stall;
  logic       rs1_pending;
  logic       rs2_pending;
  logic [1:0] inflight_cnt;
  logic       sb_error;

  int n_checks = 0;
  int n_fails  = 0;

  hazard_scoreboard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .issue_reg_write (issue_reg_write),
    .issue_is_load   (issue_is_load),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .stall_mem       (stall_mem),
    .flush_ex        (flush_ex),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .load_use_stall  (load_use_stall),
    .rs1_pending     (rs1_pending),
    .rs2_pending     (rs2_pending),
    .inflight_cnt    (inflight_cnt),
    .sb_error        (sb_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid     = 1'b0;
    issue_rd        = '0;
    issue_reg_write = 1'b0;
    issue_is_load   = 1'b0;
    ID_rs1          = '0;
    ID_rs2          = '0;
    stall_mem       = 1'b0;
    flush_ex        = 1'b0;
    wb_valid        = 1'b0;
    wb_rd           = '0;
  endtask

  task automatic offer(input logic [4:0] rd, input logic ld);
    issue_valid     = 1'b1;
    issue_rd        = rd;
    issue_reg_write = 1'b1;
    issue_is_load   = ld;
  endtask

  initial begin
    // Reset with busy inputs
    idle();
    rst_n = 1'b0;
    offer(5'd5, 1'b1);
    ID_rs1 = 5'd5; ID_rs2 = 5'd5; wb_valid = 1'b1; wb_rd = 5'd3;
    tick(); tick();
    chk("rst_load_use_stall", 32'(load_use_stall), 0);
    chk("rst_rs1_pending", 32'(rs1_pending), 0);
    chk("rst_rs2_pending", 32'(rs2_pending), 0);
    chk("rst_inflight", 32'(inflight_cnt), 0);
    chk("rst_sb_error", 32'(sb_error), 0);
    idle();
    rst_n = 1'b1;
    tick();
    chk("idle_sb_error", 32'(sb_error), 0);

    // x0 load: never pending, never a load-use stall
    offer(5'd0, 1'b1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("x0_load_use_stall", 32'(load_use_stall), 0);
    chk("x0_rs1_pending", 32'(rs1_pending), 0);
    chk("x0_inflight_ex", 32'(inflight_cnt), 1);
    tick(); tick();
    chk("x0_inflight_wb", 32'(inflight_cnt), 1);
    tick();
    chk("x0_inflight_drained", 32'(inflight_cnt), 0);
    chk("x0_sb_error", 32'(sb_error), 0);

    // Load-use on x5
    idle();
    offer(5'd5, 1'b1);
    tick();
    offer(5'd8, 1'b0);
    ID_rs1 = 5'd5;
    #1;
    chk("lu_stall_on", 32'(load_use_stall), 1);
    chk("lu_rs1_pending", 32'(rs1_pending), 1);
    tick();
    chk("lu_stall_off", 32'(load_use_stall), 0);
    chk("lu_rs1_pending_me", 32'(rs1_pending), 1);
    tick();
    chk("lu_inflight_two", 32'(inflight_cnt), 2);
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("lu_rs1_retired", 32'(rs1_pending), 0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd8;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("lu_sb_error", 32'(sb_error), 0);
    chk("lu_inflight_drained", 32'(inflight_cnt), 0);

    // Non-load add x6: pending for three advances, no stall
    idle();
    offer(5'd6, 1'b0);
    tick();
    issue_valid = 1'b0;
    ID_rs2 = 5'd6;
    #1;
    chk("add_load_use_stall", 32'(load_use_stall), 0);
    chk("add_rs2_pending_ex", 32'(rs2_pending), 1);
    tick();
    chk("add_rs2_pending_me", 32'(rs2_pending), 1);
    tick();
    chk("add_rs2_pending_wb", 32'(rs2_pending), 1);
    wb_valid = 1'b1; wb_rd = 5'd6;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("add_rs2_retired", 32'(rs2_pending), 0);

    // Three writes to x7, then retire + new write in one cycle
    idle();
    offer(5'd7, 1'b0);
    tick(); tick(); tick();
    chk("x7_inflight_three", 32'(inflight_cnt), 3);
    ID_rs1 = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    chk("x7_inflight_held", 32'(inflight_cnt), 3);
    chk("x7_rs1_pending", 32'(rs1_pending), 1);
    chk("x7_sb_error_overlap", 32'(sb_error), 0);
    issue_valid = 1'b0;
    tick(); tick();
    chk("x7_rs1_last_left", 32'(rs1_pending), 1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("x7_rs1_drained", 32'(rs1_pending), 0);
    chk("x7_sb_error", 32'(sb_error), 0);
    chk("x7_inflight_drained", 32'(inflight_cnt), 0);

    // Memory stall holds everything, including a pending flush
    idle();
    offer(5'd11, 1'b0);
    tick();
    offer(5'd12, 1'b0);
    stall_mem = 1'b1; flush_ex = 1'b1;
    ID_rs1 = 5'd11; ID_rs2 = 5'd12;
    wb_valid = 1'b1; wb_rd = 5'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_rs1_held", 32'(rs1_pending), 1);
    end
    chk("stall_rs2_not_issued", 32'(rs2_pending), 0);
    chk("stall_inflight_held", 32'(inflight_cnt), 1);
    chk("stall_sb_error", 32'(sb_error), 0);
    stall_mem = 1'b0; wb_valid = 1'b0;
    tick();
    chk("flush_rs1_cleared", 32'(rs1_pending), 0);
    chk("flush_rs2_squashed", 32'(rs2_pending), 0);
    chk("flush_inflight", 32'(inflight_cnt), 0);
    chk("flush_sb_error", 32'(sb_error), 0);

    // Writeback register mismatch is sticky until reset
    idle();
    offer(5'd9, 1'b0);
    tick();
    issue_valid = 1'b0;
    tick(); tick();
    wb_valid = 1'b1; wb_rd = 5'd10;
    #1;
    chk("mm_before_edge", 32'(sb_error), 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("mm_sb_error_set", 32'(sb_error), 1);
    tick(); tick(); tick();
    chk("mm_sb_error_sticky", 32'(sb_error), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mm_sb_error_reset", 32'(sb_error), 0);
    chk("mm_inflight_reset", 32'(inflight_cnt), 0);

    // Reset mid-flight discards entries without an error
    idle();
    offer(5'd13, 1'b0);
    tick();
    offer(5'd14, 1'b0);
    tick();
    issue_valid = 1'b0;
    ID_rs1 = 5'd13; ID_rs2 = 5'd14;
    #1;
    chk("mid_rs1_before", 32'(rs1_pending), 1);
    chk("mid_rs2_before", 32'(rs2_pending), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rs1_in_reset", 32'(rs1_pending), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rs1_after", 32'(rs1_pending), 0);
    chk("mid_rs2_after", 32'(rs2_pending), 0);
    chk("mid_inflight_after", 32'(inflight_cnt), 0);
    tick(); tick(); tick();
    chk("mid_sb_error", 32'(sb_error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
